// File: rtl/bingo_disp_pkg.sv
// Shared types and constants for the bingo display path: FSM encoding and 7-segment glyphs.
// Pure declarations, no latency or flow control of its own.
package bingo_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } disp_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [2:0] AN_OFF  = 3'b111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble: start captures din, then one add-3/shift iteration per cycle.
// done flags the 8th iteration; bcd is final the cycle after. start is only honoured when idle.
module bin2bcd_seq
    import bingo_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  bin;
    logic [11:0] acc;
    logic [11:0] adj;
    logic [19:0] shifted;
    logic [2:0]  iter;
    logic        running;

    always_comb begin
        adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj, bin} << 1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin     <= 8'd0;
            acc     <= 12'd0;
            iter    <= 3'd0;
            running <= 1'b0;
        end else if (start && !running) begin
            bin     <= din;
            acc     <= 12'd0;
            iter    <= 3'd0;
            running <= 1'b1;
        end else if (running) begin
            acc  <= shifted[19:8];
            bin  <= shifted[7:0];
            iter <= iter + 3'd1;
            if (iter == 3'd7) begin
                running <= 1'b0;
            end
        end
    end

    assign busy = running;
    assign done = running && (iter == 3'd7);
    assign bcd  = acc;

endmodule

// File: rtl/bingo_display.sv
// Bingo number display: 9-cycle load-to-commit, one-deep last-wins pending slot, muxed 3-digit 7-seg.
// No backpressure on load; optional highlight blink built only with BINGO_DISP_BLINK_EN.
module bingo_display
    import bingo_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] number_in,
    input  logic       load,
    input  logic       enable,
    input  logic       highlight,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy,
    output logic       done
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    disp_state_t state;
    logic        pend_vld;
    logic [7:0]  pend_val;
    logic [3:0]  disp_h;
    logic [3:0]  disp_t;
    logic [3:0]  disp_u;

    logic        conv_start;
    logic [7:0]  conv_din;
    logic        conv_busy;
    logic        conv_done;
    logic [11:0] conv_bcd;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rstn  (rstn),
        .start (conv_start),
        .din   (conv_din),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // A fresh load in IDLE beats a stale pending value; COMMIT chains straight into the pending one.
    always_comb begin
        conv_start = 1'b0;
        conv_din   = number_in;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    conv_start = 1'b1;
                    conv_din   = number_in;
                end else if (pend_vld) begin
                    conv_start = 1'b1;
                    conv_din   = pend_val;
                end
            end
            ST_COMMIT: begin
                if (pend_vld) begin
                    conv_start = 1'b1;
                    conv_din   = pend_val;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            pend_val <= 8'd0;
            disp_h   <= 4'd0;
            disp_t   <= 4'd0;
            disp_u   <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= conv_start;
                    if (conv_start) begin
                        state    <= ST_CONVERT;
                        pend_vld <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    busy <= 1'b1;
                    if (load) begin
                        pend_val <= number_in;
                        pend_vld <= 1'b1;
                    end
                    if (conv_done) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_h <= conv_bcd[11:8];
                    disp_t <= conv_bcd[7:4];
                    disp_u <= conv_bcd[3:0];
                    done   <= 1'b1;
                    busy   <= pend_vld;
                    state  <= pend_vld ? ST_CONVERT : ST_IDLE;
                    if (load) begin
                        pend_val <= number_in;
                        pend_vld <= 1'b1;
                    end else if (pend_vld) begin
                        pend_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [SCAN_W-1:0] presc;
    logic [1:0]        dig_idx;
    logic              scan_wrap;

    assign scan_wrap = (presc == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc   <= '0;
            dig_idx <= 2'd0;
        end else begin
            if (scan_wrap) begin
                presc   <= '0;
                dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
            end else begin
                presc <= presc + SCAN_W'(1);
            end
        end
    end

    logic blink_blank;

`ifdef BINGO_DISP_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;

    // Counter and phase restart whenever highlight drops so each blink starts visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (!highlight) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (scan_wrap) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign blink_blank = highlight && blink_ph;
`else
    logic unused_highlight;
    assign unused_highlight = highlight;
    assign blink_blank      = 1'b0;
`endif

    logic [3:0] cur_nib;
    logic       cur_show;
    logic       drive;
    logic [6:0] seg_nxt;
    logic [2:0] an_nxt;

    // Leading-zero blanking: units always lit, tens only once the value reaches 10.
    always_comb begin
        cur_nib  = disp_u;
        cur_show = 1'b0;
        case (dig_idx)
            2'd0: begin
                cur_nib  = disp_u;
                cur_show = 1'b1;
            end
            2'd1: begin
                cur_nib  = disp_t;
                cur_show = (disp_h != 4'd0) || (disp_t != 4'd0);
            end
            2'd2: begin
                cur_nib  = disp_h;
                cur_show = (disp_h != 4'd0);
            end
            default: ;
        endcase
        drive   = cur_show && enable && !blink_blank;
        an_nxt  = drive ? ~(3'b001 << dig_idx) : AN_OFF;
        seg_nxt = drive ? seg_decode(cur_nib) : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule
